// File: rtl/cpu_button_driver_if.sv
// Button-side bundle between the game logic and the autonomous opponent.
// The game side owns enable and the position feeds; the bot owns the buttons and debug state.
interface cpu_button_driver_if;
    logic       enable;
    logic [9:0] target_pos;
    logic [9:0] player_pos;
    logic       hl_button;
    logic       hr_button;
    logic [2:0] bot_state;

    modport master (
        output enable,
        output target_pos,
        output player_pos,
        input  hl_button,
        input  hr_button,
        input  bot_state
    );

    modport slave (
        input  enable,
        input  target_pos,
        input  player_pos,
        output hl_button,
        output hr_button,
        output bot_state
    );
endinterface

// File: rtl/cpu_button_driver.sv
// Autonomous opponent: waits, decides a direction toward a clamped target, holds one
// active-low button until arrival, edge or timeout, then cools down with both released.
module cpu_button_driver #(
    parameter int PLAYER_RADIUS   = 25,
    parameter int DEADBAND        = 4,
    parameter int REACTION_CYCLES = 200000,
    parameter int MAX_PUSH_CYCLES = 5000000,
    parameter int COOLDOWN_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_button_driver_if.slave   bus
);

    localparam logic [2:0] ST_WAIT     = 3'd0;
    localparam logic [2:0] ST_PUSH_L   = 3'd1;
    localparam logic [2:0] ST_PUSH_R   = 3'd2;
    localparam logic [2:0] ST_COOLDOWN = 3'd3;

    localparam int MAX_A       = (REACTION_CYCLES > MAX_PUSH_CYCLES) ? REACTION_CYCLES : MAX_PUSH_CYCLES;
    localparam int TIMER_TOP_I = (MAX_A > COOLDOWN_CYCLES) ? MAX_A : COOLDOWN_CYCLES;
    localparam int TIMER_W     = $clog2(TIMER_TOP_I + 1);

    localparam logic [TIMER_W-1:0] TIMER_TOP   = TIMER_W'(TIMER_TOP_I);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO  = TIMER_W'(0);
    localparam logic [TIMER_W-1:0] REACT_LAST  = TIMER_W'(REACTION_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PUSH_LAST   = TIMER_W'(MAX_PUSH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] COOL_LAST   = TIMER_W'(COOLDOWN_CYCLES - 1);

    // All position arithmetic is 11 bits wide so right-edge sums never overflow.
    localparam logic [10:0]        LEFT_EDGE   = 11'(144 + PLAYER_RADIUS);
    localparam logic [10:0]        RIGHT_EDGE  = 11'(660 - PLAYER_RADIUS);
    localparam logic [10:0]        DB_U        = 11'(DEADBAND);
    localparam logic signed [10:0] DB_POS      = 11'(DEADBAND);
    localparam logic signed [10:0] DB_NEG      = 11'(0 - DEADBAND);

    logic [2:0]          state_r;
    logic [2:0]          next_state_s;
    logic [TIMER_W-1:0]  timer_r;
    logic [10:0]         tgt_r;
    logic                hl_r;
    logic                hr_r;
    logic                hl_next_s;
    logic                hr_next_s;
    logic                timer_clr_s;
    logic                tgt_load_s;
    logic [10:0]         clamp_s;
    logic [10:0]         player_ext_s;
    logic signed [10:0]  diff_s;

    function automatic logic [10:0] clamp_pos(input logic [9:0] pos);
        logic [10:0] p;
        p = {1'b0, pos};
        if (p < LEFT_EDGE) begin
            clamp_pos = LEFT_EDGE;
        end else if (p > RIGHT_EDGE) begin
            clamp_pos = RIGHT_EDGE;
        end else begin
            clamp_pos = p;
        end
    endfunction

    assign player_ext_s  = {1'b0, bus.player_pos};
    assign bus.hl_button = hl_r;
    assign bus.hr_button = hr_r;
    assign bus.bot_state = state_r;

    // State, timer, latched target and button registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_WAIT;
            timer_r <= TIMER_ZERO;
            tgt_r   <= LEFT_EDGE;
            hl_r    <= 1'b1;
            hr_r    <= 1'b1;
        end else begin
            state_r <= next_state_s;
            hl_r    <= hl_next_s;
            hr_r    <= hr_next_s;
            if (timer_clr_s || (next_state_s != state_r)) begin
                timer_r <= TIMER_ZERO;
            end else if (timer_r != TIMER_TOP) begin
                timer_r <= timer_r + TIMER_ONE;
            end else begin
                timer_r <= timer_r;
            end
            if (tgt_load_s) begin
                tgt_r <= clamp_s;
            end else begin
                tgt_r <= tgt_r;
            end
        end
    end

    // Next-state decision, push stop conditions and parking on disable.
    always_comb begin
        next_state_s = state_r;
        timer_clr_s  = 1'b0;
        tgt_load_s   = 1'b0;
        clamp_s      = clamp_pos(bus.target_pos);
        diff_s       = clamp_s - player_ext_s;
        if (!bus.enable) begin
            next_state_s = ST_WAIT;
            timer_clr_s  = 1'b1;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (timer_r == REACT_LAST) begin
                        tgt_load_s = 1'b1;
                        if (diff_s > DB_POS) begin
                            next_state_s = ST_PUSH_R;
                        end else if (diff_s < DB_NEG) begin
                            next_state_s = ST_PUSH_L;
                        end else begin
                            next_state_s = ST_WAIT;
                            timer_clr_s  = 1'b1;
                        end
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end
                ST_PUSH_R: begin
                    if ((player_ext_s + DB_U >= tgt_r) || (player_ext_s >= RIGHT_EDGE) ||
                        (timer_r == PUSH_LAST)) begin
                        next_state_s = ST_COOLDOWN;
                    end else begin
                        next_state_s = ST_PUSH_R;
                    end
                end
                ST_PUSH_L: begin
                    if ((player_ext_s <= tgt_r + DB_U) || (player_ext_s <= LEFT_EDGE) ||
                        (timer_r == PUSH_LAST)) begin
                        next_state_s = ST_COOLDOWN;
                    end else begin
                        next_state_s = ST_PUSH_L;
                    end
                end
                ST_COOLDOWN: begin
                    if (timer_r == COOL_LAST) begin
                        next_state_s = ST_WAIT;
                    end else begin
                        next_state_s = ST_COOLDOWN;
                    end
                end
                default: begin
                    next_state_s = ST_WAIT;
                end
            endcase
        end
    end

    // Button levels decoded from the upcoming state so they register together with it.
    always_comb begin
        hl_next_s = 1'b1;
        hr_next_s = 1'b1;
        case (next_state_s)
            ST_PUSH_L: hl_next_s = 1'b0;
            ST_PUSH_R: hr_next_s = 1'b0;
            default: begin
                hl_next_s = 1'b1;
                hr_next_s = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_button_driver.sv
// Bench for cpu_button_driver: directed scenarios plus random chases, all checked
// against a phase-level timeline model that also emulates the player controller.
module tb_cpu_button_driver;

    localparam int R  = 10;
    localparam int M  = 50;
    localparam int C  = 5;
    localparam int DB = 4;
    localparam int PR = 25;
    localparam int LE = 144 + PR;
    localparam int RE = 660 - PR;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    cpu_button_driver_if bus ();

    cpu_button_driver #(
        .PLAYER_RADIUS   (PR),
        .DEADBAND        (DB),
        .REACTION_CYCLES (R),
        .MAX_PUSH_CYCLES (M),
        .COOLDOWN_CYCLES (C)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected observables for a spec state code: 0 wait, 1 left, 2 right, 3 cooldown.
    task automatic expect_state(input string tag, input int st);
        check({tag, "_state"}, {7'd0, bus.bot_state}, 10'(st));
        check({tag, "_hl"}, {9'd0, bus.hl_button}, (st == 1) ? 10'd0 : 10'd1);
        check({tag, "_hr"}, {9'd0, bus.hr_button}, (st == 2) ? 10'd0 : 10'd1);
    endtask

    function automatic int clampv(input int v);
        if (v < LE) return LE;
        if (v > RE) return RE;
        return v;
    endfunction

    task automatic wait_then_press(input string tag, input int st);
        for (int j = 0; j < R; j++) begin
            expect_state({tag, "_wait"}, 0);
            next_cycle();
        end
        expect_state({tag, "_press"}, st);
    endtask

    // Start from a parked bot, then play n_dec decisions; the player moves by step per
    // pressed cycle and the target switches to tgt_mid on the first pushed cycle.
    task automatic run_episode(input string tag, input int tgt0, input int p0, input int step,
                               input int tgt_mid, input int n_dec);
        int  ply;
        int  cur_tgt;
        int  ct;
        int  diff;
        int  dir;
        bit  stop;
        bit  mid_done;
        ply      = p0;
        cur_tgt  = tgt0;
        mid_done = 1'b0;
        ct       = LE;
        dir      = 0;
        bus.enable     = 1'b0;
        bus.target_pos = 10'(tgt0);
        bus.player_pos = 10'(p0);
        next_cycle();
        bus.enable = 1'b1;
        for (int d = 0; d < n_dec; d++) begin
            for (int j = 0; j < R; j++) begin
                expect_state({tag, "_wait"}, 0);
                if (j == R - 1) begin
                    ct   = clampv(cur_tgt);
                    diff = ct - ply;
                    dir  = (diff > DB) ? 1 : ((diff < -DB) ? -1 : 0);
                end
                next_cycle();
            end
            if (dir != 0) begin
                for (int k = 0; k < M; k++) begin
                    expect_state({tag, "_push"}, (dir > 0) ? 2 : 1);
                    if (!mid_done) begin
                        cur_tgt        = tgt_mid;
                        bus.target_pos = 10'(tgt_mid);
                        mid_done       = 1'b1;
                    end
                    ply            = ply + dir * step;
                    bus.player_pos = 10'(ply);
                    if (dir > 0) stop = (ply + DB >= ct) || (ply >= RE);
                    else         stop = (ply <= ct + DB) || (ply <= LE);
                    if (k == M - 1) stop = 1'b1;
                    next_cycle();
                    if (stop) break;
                end
                for (int j = 0; j < C; j++) begin
                    expect_state({tag, "_cool"}, 3);
                    next_cycle();
                end
            end
        end
        expect_state({tag, "_end"}, 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.enable     = 1'b1;
        bus.target_pos = 10'd500;
        bus.player_pos = 10'd300;
        next_cycle();
        next_cycle();
        expect_state("reset", 0);
        rst = 1'b0;
        wait_then_press("first", 2);

        // Reset in the middle of a right push.
        next_cycle();
        next_cycle();
        expect_state("pre_rst", 2);
        rst = 1'b1;
        next_cycle();
        expect_state("rst_c1", 0);
        next_cycle();
        expect_state("rst_c2", 0);
        rst = 1'b0;
        wait_then_press("post_rst", 2);

        // Disable mid-push: released at the next edge and held parked.
        bus.enable = 1'b0;
        for (int j = 0; j < 4; j++) begin
            next_cycle();
            expect_state("disabled", 0);
        end

        run_episode("chase_r",   400, 300, 2, 400, 1);
        run_episode("tgt_chg",   400, 300, 2, 200, 1);
        run_episode("deadband",  300, 303, 1, 300, 3);
        run_episode("clamp_l",    50, 251, 2,  50, 1);
        run_episode("clamp_hold", 50, 169, 1,  50, 2);
        run_episode("timeout",   500, 300, 0, 500, 2);
        run_episode("edge_r",   1000, 600, 3, 900, 2);

        for (int e = 0; e < 12; e++) begin
            run_episode("rand", int'($urandom_range(0, 1023)), int'($urandom_range(0, 1000)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
